// File: rtl/key_debounce_if.sv
// Key conditioning bundle: raw pin in, debounced level and strobes out.
// Master drives the pin and observes; slave is the debouncer.
interface key_debounce_if;
  logic key_in;
  logic key_level;
  logic key_press;
  logic key_release;
  logic key_long;

  modport master (
    output key_in,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_long
  );

  modport slave (
    input  key_in,
    output key_level,
    output key_press,
    output key_release,
    output key_long
  );
endinterface

// File: rtl/key_debounce.sv
// Push-button synchroniser and counter-qualified debouncer with strobes.
// Define KEY_DEBOUNCE_LONG_PRESS_EN to build the long-press strobe.
module key_debounce #(
  parameter int   DEBOUNCE_CYCLES   = 1_000_000,
  parameter int   LONG_PRESS_CYCLES = 50_000_000,
  parameter logic KEY_ACTIVE_LEVEL  = 1'b0
) (
  input  logic          system_clk,
  input  logic          system_reset,
  key_debounce_if.slave kif
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          s1_q, s2_q;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          release_q, release_d;
  logic          pr;

  assign pr = (s2_q == KEY_ACTIVE_LEVEL);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pr) begin
          state_d = PRESS_WAIT;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!pr) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      PRESSED: begin
        if (!pr) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CW'(1);
        end else begin
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (pr) begin
          state_d   = PRESSED;
          cnt_d     = '0;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
          cnt_d     = '0;
        end else begin
          cnt_d     = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      s1_q      <= ~KEY_ACTIVE_LEVEL;
      s2_q      <= ~KEY_ACTIVE_LEVEL;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= kif.key_in;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign kif.key_level   = level_q;
  assign kif.key_press   = press_q;
  assign kif.key_release = release_q;

`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam int LW = $clog2(LONG_PRESS_CYCLES);
  localparam logic [LW-1:0] LCNT_MAX = LW'(LONG_PRESS_CYCLES - 1);

  logic [LW-1:0] lcnt_q, lcnt_d;
  logic          ldone_q, ldone_d;
  logic          long_q, long_d;

  // Saturate at max; the done flag keeps it to one strobe per press.
  always_comb begin
    lcnt_d  = lcnt_q;
    ldone_d = ldone_q;
    long_d  = 1'b0;
    if (level_q) begin
      if (lcnt_q == LCNT_MAX) begin
        if (!ldone_q) begin
          long_d  = 1'b1;
          ldone_d = 1'b1;
        end
      end else begin
        lcnt_d = lcnt_q + LW'(1);
      end
    end
    if (press_d || release_d) begin
      lcnt_d  = '0;
      ldone_d = 1'b0;
    end
  end

  always_ff @(posedge system_clk) begin
    if (system_reset) begin
      lcnt_q  <= '0;
      ldone_q <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      lcnt_q  <= lcnt_d;
      ldone_q <= ldone_d;
      long_q  <= long_d;
    end
  end

  assign kif.key_long = long_q;
`else
  logic unused_long_cfg;
  assign unused_long_cfg = (LONG_PRESS_CYCLES > 1);
  assign kif.key_long    = 1'b0;
`endif

endmodule

// File: tb/tb_key_debounce.sv
// Bench for key_debounce: per-cycle reference model with scoreboard,
// scenario table with event counts, plus hand-written latency checks.
module tb_key_debounce;

  localparam int   D    = 8;
  localparam int   LONG = 32;
  localparam logic ACT  = 1'b0;
`ifdef KEY_DEBOUNCE_LONG_PRESS_EN
  localparam logic LEN  = 1'b1;
  localparam int   LEXP = 1;
`else
  localparam logic LEN  = 1'b0;
  localparam int   LEXP = 0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_debounce_if kif ();

  key_debounce #(
    .DEBOUNCE_CYCLES   (D),
    .LONG_PRESS_CYCLES (LONG),
    .KEY_ACTIVE_LEVEL  (ACT)
  ) dut (
    .system_clk   (clk),
    .system_reset (rst),
    .kif          (kif)
  );

  always #10 clk = ~clk;

  typedef struct packed {
    logic       rst;
    logic       key;
    logic [7:0] cyc;
  } seg_t;

  typedef struct {
    int        id;
    int        nseg;
    seg_t [5:0] seg;
    int        exp_press;
    int        exp_rel;
    int        exp_long;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] sb_q[$];

  logic ms1, ms2, mlevel;
  int   mrun, msince;
  int   c_press, c_rel, c_long;

  function automatic seg_t sg(input logic r, input logic k, input int c);
    seg_t s;
    s.rst = r;
    s.key = k;
    s.cyc = 8'(c);
    return s;
  endfunction

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Reference: accept a new level once D consecutive synchronised
  // samples differ from the current level.
  task automatic model(input logic r, input logic k,
                       output logic [3:0] e);
    logic pr, mp, mr, ml;
    mp = 1'b0;
    mr = 1'b0;
    ml = 1'b0;
    if (r) begin
      ms1    = ~ACT;
      ms2    = ~ACT;
      mlevel = 1'b0;
      mrun   = 0;
      msince = 0;
    end else begin
      pr = (ms2 == ACT);
      if (mlevel) begin
        msince++;
        if (msince == LONG) ml = LEN;
      end
      if (pr != mlevel) begin
        mrun++;
        if (mrun == D) begin
          mlevel = pr;
          mp     = pr;
          mr     = ~pr;
          mrun   = 0;
          msince = 0;
        end
      end else begin
        mrun = 0;
      end
      ms2 = ms1;
      ms1 = k;
    end
    e = {mlevel, mp, mr, ml};
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic r, input logic k);
    logic [3:0] e;
    logic [3:0] a;
    rst        = r;
    kif.key_in = k;
    @(posedge clk);
    model(r, k, e);
    sb_q.push_back(e);
    @(negedge clk);
    a = {kif.key_level, kif.key_press, kif.key_release, kif.key_long};
    check("cycle_outputs", 32'(a), 32'(sb_q.pop_front()));
    c_press += int'(kif.key_press);
    c_rel   += int'(kif.key_release);
    c_long  += int'(kif.key_long);
  endtask

  vec_t vt[7];

  initial begin
    int n;
    kif.key_in = 1'b1;
    c_press = 0;
    c_rel   = 0;
    c_long  = 0;

    vt[0] = '{0, 2, '{default: '0}, 1, 0, 0};
    vt[0].seg[0] = sg(1, 1, 2);
    vt[0].seg[1] = sg(0, 0, 20);
    vt[1] = '{1, 5, '{default: '0}, 0, 0, 0};
    vt[1].seg[0] = sg(1, 1, 2);
    vt[1].seg[1] = sg(0, 0, 3);
    vt[1].seg[2] = sg(0, 1, 3);
    vt[1].seg[3] = sg(0, 0, 3);
    vt[1].seg[4] = sg(0, 1, 20);
    vt[2] = '{2, 3, '{default: '0}, 1, 1, 0};
    vt[2].seg[0] = sg(1, 1, 2);
    vt[2].seg[1] = sg(0, 0, D);
    vt[2].seg[2] = sg(0, 1, 20);
    vt[3] = '{3, 3, '{default: '0}, 0, 0, 0};
    vt[3].seg[0] = sg(1, 1, 2);
    vt[3].seg[1] = sg(0, 0, D - 1);
    vt[3].seg[2] = sg(0, 1, 20);
    vt[4] = '{4, 5, '{default: '0}, 1, 1, 0};
    vt[4].seg[0] = sg(1, 1, 2);
    vt[4].seg[1] = sg(0, 0, 12);
    vt[4].seg[2] = sg(0, 1, 5);
    vt[4].seg[3] = sg(0, 0, 10);
    vt[4].seg[4] = sg(0, 1, 12);
    vt[5] = '{5, 4, '{default: '0}, 2, 0, 0};
    vt[5].seg[0] = sg(1, 1, 2);
    vt[5].seg[1] = sg(0, 0, 12);
    vt[5].seg[2] = sg(1, 0, 1);
    vt[5].seg[3] = sg(0, 0, 14);
    vt[6] = '{6, 3, '{default: '0}, 1, 1, LEXP};
    vt[6].seg[0] = sg(1, 1, 2);
    vt[6].seg[1] = sg(0, 0, 70);
    vt[6].seg[2] = sg(0, 1, 12);

    @(negedge clk);
    step(1, 1);
    check("reset_level", 32'(kif.key_level), 0);
    check("reset_strobes",
          32'({kif.key_press, kif.key_release, kif.key_long}), 0);

    foreach (vt[v]) begin
      c_press = 0;
      c_rel   = 0;
      c_long  = 0;
      for (int s = 0; s < vt[v].nseg; s++)
        for (int c = 0; c < int'(vt[v].seg[s].cyc); c++)
          step(vt[v].seg[s].rst, vt[v].seg[s].key);
      $display("[TB] scenario %0d: press=%0d release=%0d long=%0d",
               vt[v].id, c_press, c_rel, c_long);
      check("scn_press_count", 32'(c_press), 32'(vt[v].exp_press));
      check("scn_release_count", 32'(c_rel), 32'(vt[v].exp_rel));
      check("scn_long_count", 32'(c_long), 32'(vt[v].exp_long));
    end

    // Press latency counted from the reset edge.
    step(1, 1);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      step(0, 0);
      if (kif.key_press) n = i;
    end
    check("press_latency", 32'(n), 32'(D + 2));
    step(0, 0);
    check("press_one_cycle", 32'(kif.key_press), 0);
    check("level_held", 32'(kif.key_level), 1);

    // Reset while pressed: level drops without a release strobe.
    step(1, 0);
    check("rst_mid_level", 32'(kif.key_level), 0);
    check("rst_mid_release", 32'(kif.key_release), 0);
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      step(0, 0);
      if (kif.key_press) n = i;
    end
    check("repress_latency", 32'(n), 32'(D + 2));

    // Release latency: D high samples after the last low one.
    n = 0;
    for (int i = 1; i <= 40 && n == 0; i++) begin
      step(0, 1);
      if (kif.key_release) n = i;
    end
    check("release_latency", 32'(n), 32'(D + 2));
    check("release_level", 32'(kif.key_level), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
